// File: rtl/note_sequencer.sv
// ============================================================================
// Module   : note_sequencer
// Purpose  : Reads {duration, period} notes from song memory and drives a PWM
//            tone generator, with a silent gap after each note.
//            Define NOTE_SEQ_LOOP_EN to replay the song instead of stopping
//            at the end marker or address wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_sequencer #(
    parameter int CLK_FREQ     = 50000000,
    parameter int ADDR_WIDTH   = 12,
    parameter int PERIOD_WIDTH = 20,
    parameter int DUR_WIDTH    = 12,
    parameter int GAP_MS       = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stop,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic                              mem_rd,
    input  logic [DUR_WIDTH+PERIOD_WIDTH-1:0] mem_data,
    output logic [PERIOD_WIDTH-1:0]           tone_period,
    output logic                              tone_en,
    output logic                              busy,
    output logic                              done
);

    localparam int C_TICK  = CLK_FREQ / 1000;
    localparam int C_PRE_W = (C_TICK > 1) ? $clog2(C_TICK) : 1;
    localparam int C_GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
    localparam int C_CNT_W = (DUR_WIDTH > C_GAP_W) ? DUR_WIDTH : C_GAP_W;

    localparam logic [C_PRE_W-1:0]    C_PRE_LAST = C_PRE_W'(C_TICK - 1);
    localparam logic [C_PRE_W-1:0]    C_PRE_ONE  = C_PRE_W'(1);
    localparam logic [C_CNT_W-1:0]    C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0]    C_GAP_LOAD = C_CNT_W'(GAP_MS);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_rd_q, mem_rd_d;
    logic [PERIOD_WIDTH-1:0] tone_period_q, tone_period_d;
    logic                    tone_en_q, tone_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [C_PRE_W-1:0]      presc_q, presc_d;
    logic [C_CNT_W-1:0]      ms_cnt_q, ms_cnt_d;

    logic [DUR_WIDTH-1:0]    w_note_dur;
    logic [PERIOD_WIDTH-1:0] w_note_per;
    logic                    w_ms_tick;
    logic                    w_last_ms;
    logic                    w_next_note;
    logic                    w_end_song;

    assign w_note_dur = mem_data[DUR_WIDTH+PERIOD_WIDTH-1:PERIOD_WIDTH];
    assign w_note_per = mem_data[PERIOD_WIDTH-1:0];
    assign w_ms_tick  = (presc_q == C_PRE_LAST);
    assign w_last_ms  = (ms_cnt_q == C_CNT_ONE);

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = 1'b0;
        tone_period_d = tone_period_q;
        tone_en_d     = tone_en_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        presc_d       = presc_q;
        ms_cnt_d      = ms_cnt_q;
        w_next_note   = 1'b0;
        w_end_song    = 1'b0;

        // Abort wins over everything else; the last period is left on the bus.
        if (stop && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            mem_addr_d = '0;
            tone_en_d  = 1'b0;
            busy_d     = 1'b0;
            presc_d    = '0;
            ms_cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d    = S_FETCH;
                        mem_addr_d = '0;
                        mem_rd_d   = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
                S_FETCH: begin
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    if (w_note_dur == '0) begin
                        w_end_song = 1'b1;
                    end else begin
                        tone_period_d = w_note_per;
                        tone_en_d     = (w_note_per != '0);
                        ms_cnt_d      = C_CNT_W'(w_note_dur);
                        presc_d       = '0;
                        state_d       = S_PLAY;
                    end
                end
                S_PLAY, S_GAP: begin
                    presc_d = w_ms_tick ? '0 : (presc_q + C_PRE_ONE);
                    if (w_ms_tick) begin
                        if (w_last_ms) begin
                            tone_en_d = 1'b0;
                            if ((state_q == S_PLAY) && (GAP_MS > 0)) begin
                                state_d  = S_GAP;
                                ms_cnt_d = C_GAP_LOAD;
                            end else begin
                                w_next_note = 1'b1;
                            end
                        end else begin
                            ms_cnt_d = ms_cnt_q - C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // The last address doubles as an implicit end marker.
            if (w_next_note) begin
                ms_cnt_d = '0;
                presc_d  = '0;
                if (mem_addr_q == {ADDR_WIDTH{1'b1}}) begin
                    w_end_song = 1'b1;
                end else begin
                    mem_addr_d = mem_addr_q + C_ADDR_ONE;
                    mem_rd_d   = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            if (w_end_song) begin
                done_d     = 1'b1;
                tone_en_d  = 1'b0;
                mem_addr_d = '0;
                ms_cnt_d   = '0;
                presc_d    = '0;
`ifdef NOTE_SEQ_LOOP_EN
                mem_rd_d   = 1'b1;
                state_d    = S_FETCH;
`else
                busy_d     = 1'b0;
                state_d    = S_IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            tone_period_q <= '0;
            tone_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            presc_q       <= '0;
            ms_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            tone_period_q <= tone_period_d;
            tone_en_q     <= tone_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            presc_q       <= presc_d;
            ms_cnt_q      <= ms_cnt_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign tone_period = tone_period_q;
    assign tone_en     = tone_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ============================================================================
// Module   : tb_note_sequencer
// Purpose  : Scoreboard bench for note_sequencer; a timeline model predicts
//            output events per playback, a monitor matches DUT events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_sequencer;

    localparam int CLK_FREQ = 4000;
    localparam int AW       = 2;
    localparam int PW       = 10;
    localparam int DW       = 4;
    localparam int GAP_MS   = 1;
    localparam int TK       = CLK_FREQ / 1000;
    localparam int DEPTH    = 1 << AW;
    localparam int W        = 100;

    localparam int EV_BUSY = 0;
    localparam int EV_RD   = 1;
    localparam int EV_TONE = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW+PW-1:0] mem_data = '0;
    logic [PW-1:0] tone_period;
    logic          tone_en;
    logic          busy;
    logic          done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];
    int   mem_dur[DEPTH];
    int   mem_per[DEPTH];
    int   cur_per = 0;

    logic          p_busy = 1'b0;
    logic [PW:0]   p_tone = '0;

    note_sequencer #(
        .CLK_FREQ    (CLK_FREQ),
        .ADDR_WIDTH  (AW),
        .PERIOD_WIDTH(PW),
        .DUR_WIDTH   (DW),
        .GAP_MS      (GAP_MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .tone_period(tone_period),
        .tone_en    (tone_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous song memory; garbage on the bus whenever no read is pending.
    always @(posedge clk) begin
        logic [31:0] junk;
        junk = $urandom;
        if (mem_rd === 1'b1)
            mem_data <= {4'(mem_dur[mem_addr]), 10'(mem_per[mem_addr])};
        else
            mem_data <= junk[DW+PW-1:0];
    end

    function automatic string kname(input int k);
        case (k)
            EV_BUSY: return "busy";
            EV_RD:   return "mem_rd_addr";
            EV_TONE: return "tone_en_period";
            default: return "done";
        endcase
    endfunction

    task automatic observe(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: cycle %0d got value %0d, required no event",
                     kname(kind), cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL event_%s: got cycle %0d %s=%0d, required cycle %0d %s=%0d",
                         kname(kind), cyc, kname(kind), val, e.cyc, kname(e.kind), e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_%s: required at cycle %0d value %0d, not seen",
                         kname(exp_q[0].kind), exp_q[0].cyc, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (busy !== p_busy) observe(EV_BUSY, int'(busy));
            if (mem_rd === 1'b1) observe(EV_RD, int'(mem_addr));
            if ({tone_en, tone_period} !== p_tone) observe(EV_TONE, int'({tone_en, tone_period}));
            if (done === 1'b1) observe(EV_DONE, 1);
        end
        p_busy = busy;
        p_tone = {tone_en, tone_period};
    end

    // Timeline model: offsets are relative to the start cycle s.
    task automatic plan(input int s, input int stop_c, input int rst_c);
        int b[W+20], r[W+20], ad[W+20], en[W+20], pr[W+20], dn[W+20];
        int t, a, fin, d, p;
        bit going;
        ev_t e;
        for (int i = 0; i < W + 20; i++) begin
            b[i] = 0; r[i] = 0; ad[i] = 0; en[i] = 0; pr[i] = cur_per; dn[i] = 0;
        end
        t = 1; a = 0; fin = W + 1; going = 1'b1;
        while (going) begin
            r[t] = 1; ad[t] = a;
            d = mem_dur[a]; p = mem_per[a];
            if (d == 0) begin
                dn[t+2] = 1; fin = t + 2; going = 1'b0;
            end else begin
                for (int c = t + 2; c < W + 20; c++) pr[c] = p;
                for (int c = t + 2; c < t + 2 + d * TK; c++) en[c] = (p != 0) ? 1 : 0;
                t = t + 2 + d * TK + GAP_MS * TK;
                if (a == DEPTH - 1) begin
                    dn[t] = 1; fin = t; going = 1'b0;
                end else begin
                    a++;
                end
            end
        end
        for (int c = 1; c < fin; c++) b[c] = 1;
        if (stop_c >= 0 && (stop_c == 0 || b[stop_c] == 1)) begin
            for (int c = stop_c + 1; c < W + 20; c++) begin
                b[c] = 0; r[c] = 0; en[c] = 0; dn[c] = 0; pr[c] = pr[stop_c];
            end
        end
        if (rst_c >= 0) begin
            for (int c = rst_c + 1; c < W + 20; c++) begin
                b[c] = 0; r[c] = 0; en[c] = 0; dn[c] = 0; pr[c] = 0;
            end
        end
        for (int c = 1; c <= W; c++) begin
            if (b[c] != b[c-1]) begin e.cyc = s + c; e.kind = EV_BUSY; e.val = b[c]; exp_q.push_back(e); end
            if (r[c] == 1) begin e.cyc = s + c; e.kind = EV_RD; e.val = ad[c]; exp_q.push_back(e); end
            if (en[c] != en[c-1] || pr[c] != pr[c-1]) begin
                e.cyc = s + c; e.kind = EV_TONE; e.val = en[c] * (1 << PW) + pr[c]; exp_q.push_back(e);
            end
            if (dn[c] == 1) begin e.cyc = s + c; e.kind = EV_DONE; e.val = 1; exp_q.push_back(e); end
        end
        cur_per = pr[W];
    endtask

    task automatic set_mem(input int d0, input int p0, input int d1, input int p1,
                           input int d2, input int p2, input int d3, input int p3);
        mem_dur[0] = d0; mem_per[0] = p0; mem_dur[1] = d1; mem_per[1] = p1;
        mem_dur[2] = d2; mem_per[2] = p2; mem_dur[3] = d3; mem_per[3] = p3;
    endtask

    // start at offset 0; stop/reset/extra start at the given offsets (-1 = none)
    task automatic run_scn(input int stop_c, input int rst_c, input int xs);
        int s;
        @(posedge clk); #1;
        s = cyc;
        plan(s, stop_c, rst_c);
        for (int i = 0; i <= W; i++) begin
            start = (i == 0) || (i == xs);
            stop  = (i == stop_c);
            reset = (i == rst_c);
            @(posedge clk); #1;
        end
        start = 1'b0; stop = 1'b0; reset = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, rc;
        set_mem(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_addr", int'(mem_addr), 0);
        chk("reset_mem_rd", int'(mem_rd), 0);
        chk("reset_tone_period", int'(tone_period), 0);
        chk("reset_tone_en", int'(tone_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        mon_en = 1'b1;

        set_mem(2, 100, 0, 0, 3, 5, 1, 1);      run_scn(-1, -1, -1);
        set_mem(1, 0, 1, 55, 0, 0, 2, 2);       run_scn(-1, -1, -1);
        set_mem(2, 77, 0, 0, 1, 1, 1, 1);       run_scn(5, -1, -1);
        set_mem(2, 66, 0, 0, 1, 1, 1, 1);       run_scn(0, -1, -1);
        set_mem(2, 33, 1, 44, 0, 0, 1, 1);      run_scn(-1, -1, 6);
        set_mem(1, 10, 1, 20, 2, 0, 1, 40);     run_scn(-1, -1, -1);
        set_mem(3, 200, 1, 1, 0, 0, 0, 0);      run_scn(-1, 6, -1);
        run_scn(-1, -1, -1);

        for (int k = 0; k < 20; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_dur[a] = $urandom_range(0, 3);
                mem_per[a] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1023);
            end
            sc = ($urandom_range(0, 9) < 4) ? $urandom_range(1, 70) : -1;
            rc = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 70) : -1;
            run_scn(sc, rc, -1);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_%s: required at cycle %0d value %0d, not seen",
                     kname(exp_q[0].kind), exp_q[0].cyc, exp_q[0].val);
            void'(exp_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
